// File: rtl/d_ctrl_pkg.sv
// Shared types and constants for the SD D-line block sequencer (d_ctrl)
// and its D0 status/busy receiver.
package d_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RCV_START,
        ST_RCV_WAIT,
        ST_RETRY,
        ST_PROC_START,
        ST_PROC_WAIT,
        ST_WR_CMD,
        ST_SEND_START,
        ST_SEND_WAIT,
        ST_STATUS,
        ST_BUSY,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        RX_START,
        RX_BITS,
        RX_END,
        RX_BUSY
    } rx_phase_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_RD_CRC  = 2'd1;
    localparam logic [1:0] ERR_WR_REJ  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Card CRC status token meaning "data accepted"
    localparam logic [2:0] STATUS_TOKEN_OK = 3'b010;

    // Cycles at the start of RCV_WAIT during which the driver CRC-fail level is stale
    localparam int CRC_BLANK = 2;

    // States in which the wait timeout counter runs
    function automatic logic is_timed(input state_t s);
        return (s == ST_RD_CMD)    || (s == ST_WR_CMD)    ||
               (s == ST_RCV_WAIT)  || (s == ST_PROC_WAIT) ||
               (s == ST_SEND_WAIT) || (s == ST_STATUS)    ||
               (s == ST_BUSY);
    endfunction

endpackage

// File: rtl/d_ctrl_d0_status_rx.sv
// D0 status receiver: finds the start bit, shifts in the 3-bit CRC status
// token MSB first, skips the end bit, then flags the release of card busy.
// Held in its start phase whenever en is low.
import d_ctrl_pkg::*;

module d0_status_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       d0,
    output logic       token_valid,
    output logic [2:0] token,
    output logic       busy_release
);

    rx_phase_t  phase;
    logic [1:0] bit_cnt;
    logic [1:0] shift_bits;

    // Sampling phase, bit counter and the first two token bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= RX_START;
            bit_cnt    <= 2'd0;
            shift_bits <= 2'b00;
        end else if (!en) begin
            phase      <= RX_START;
            bit_cnt    <= 2'd0;
            shift_bits <= 2'b00;
        end else begin
            case (phase)
                RX_START: begin
                    if (!d0) begin
                        phase   <= RX_BITS;
                        bit_cnt <= 2'd0;
                    end
                end
                RX_BITS: begin
                    shift_bits <= {shift_bits[0], d0};
                    bit_cnt    <= bit_cnt + 2'd1;
                    if (bit_cnt == 2'd2) begin
                        phase <= RX_END;
                    end
                end
                RX_END:  phase <= RX_BUSY;
                RX_BUSY: phase <= RX_BUSY;
                default: phase <= RX_START;
            endcase
        end
    end

    // Token completes on the third bit; busy ends when D0 is seen high
    always_comb begin
        token_valid  = en && (phase == RX_BITS) && (bit_cnt == 2'd2);
        token        = {shift_bits, d0};
        busy_release = en && (phase == RX_BUSY) && d0;
    end

endmodule

// File: rtl/d_ctrl.sv
// d_ctrl: sequences one SD block pass (read, process, write back, CRC status,
// busy wait) with a timeout on every wait state.
// Optional macro D_CTRL_RETRY_EN adds re-reads after a receive CRC failure.
import d_ctrl_pkg::*;

module d_ctrl #(
    parameter int TIMEOUT_W = 20,
    parameter int MAX_RETRY = 3
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       istart,
    output logic       ord_cmd_req,
    input  logic       ird_cmd_ack,
    output logic       owr_cmd_req,
    input  logic       iwr_cmd_ack,
    output logic       odrv_start,
    input  logic       idrv_done,
    input  logic       idrv_crc_fail,
    output logic       oproc_start,
    input  logic       iproc_done,
    input  logic       id0,
    output logic       obusy,
    output logic       odone,
    output logic [1:0] oerr
);

    localparam logic [TIMEOUT_W-1:0] CRC_BLANK_CNT = TIMEOUT_W'(CRC_BLANK);

    state_t                 state, next_state;
    logic [1:0]             next_err;
    logic [TIMEOUT_W-1:0]   tmo_cnt;
    logic                   tmo_hit;
    logic                   crc_armed;
    logic                   token_valid;
    logic [2:0]             token;
    logic                   busy_release;

`ifdef D_CTRL_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry_cnt, next_retry;
`endif

    assign tmo_hit   = &tmo_cnt;
    assign crc_armed = (tmo_cnt >= CRC_BLANK_CNT);
    assign obusy     = (state != ST_IDLE);

    d0_status_rx u_status_rx (
        .clk          (iclk),
        .rst_n        (irst_n),
        .en           ((state == ST_STATUS) || (state == ST_BUSY)),
        .d0           (id0),
        .token_valid  (token_valid),
        .token        (token),
        .busy_release (busy_release)
    );

    // State, result code and retry count registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state     <= ST_IDLE;
            oerr      <= ERR_OK;
`ifdef D_CTRL_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            state     <= next_state;
            oerr      <= next_err;
`ifdef D_CTRL_RETRY_EN
            retry_cnt <= next_retry;
`endif
        end
    end

    // Wait timeout: restarts on every state change, counts only in wait states
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            tmo_cnt <= '0;
        end else if (state != next_state) begin
            tmo_cnt <= '0;
        end else if (is_timed(state)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Next state, result code and Moore outputs; awaited events beat the timeout
    always_comb begin
        next_state  = state;
        next_err    = oerr;
`ifdef D_CTRL_RETRY_EN
        next_retry  = retry_cnt;
`endif
        ord_cmd_req = 1'b0;
        owr_cmd_req = 1'b0;
        odrv_start  = 1'b0;
        oproc_start = 1'b0;
        odone       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (istart) begin
                    next_state = ST_RD_CMD;
                    next_err   = ERR_OK;
                end
            end
            ST_RD_CMD: begin
                ord_cmd_req = 1'b1;
                if (ird_cmd_ack) begin
                    next_state = ST_RCV_START;
                end else if (tmo_hit) begin
                    next_state = ST_FINISH;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_RCV_START: begin
                odrv_start = 1'b1;
                next_state = ST_RCV_WAIT;
            end
            ST_RCV_WAIT: begin
                if (idrv_done) begin
                    next_state = ST_PROC_START;
                end else if (idrv_crc_fail && crc_armed) begin
`ifdef D_CTRL_RETRY_EN
                    next_state = ST_RETRY;
`else
                    next_state = ST_FINISH;
                    next_err   = ERR_RD_CRC;
`endif
                end else if (tmo_hit) begin
                    next_state = ST_FINISH;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_RETRY: begin
`ifdef D_CTRL_RETRY_EN
                if (retry_cnt < RETRY_LIMIT) begin
                    next_retry = retry_cnt + 1'b1;
                    next_state = ST_RD_CMD;
                end else begin
                    next_state = ST_FINISH;
                    next_err   = ERR_RD_CRC;
                end
`else
                next_state = ST_FINISH;
                next_err   = ERR_RD_CRC;
`endif
            end
            ST_PROC_START: begin
                oproc_start = 1'b1;
                next_state  = ST_PROC_WAIT;
            end
            ST_PROC_WAIT: begin
                if (iproc_done) begin
                    next_state = ST_WR_CMD;
                end else if (tmo_hit) begin
                    next_state = ST_FINISH;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_WR_CMD: begin
                owr_cmd_req = 1'b1;
                if (iwr_cmd_ack) begin
                    next_state = ST_SEND_START;
                end else if (tmo_hit) begin
                    next_state = ST_FINISH;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_SEND_START: begin
                odrv_start = 1'b1;
                next_state = ST_SEND_WAIT;
            end
            ST_SEND_WAIT: begin
                if (idrv_done) begin
                    next_state = ST_STATUS;
                end else if (tmo_hit) begin
                    next_state = ST_FINISH;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_STATUS: begin
                if (token_valid) begin
                    if (token == STATUS_TOKEN_OK) begin
                        next_state = ST_BUSY;
                    end else begin
                        next_state = ST_FINISH;
                        next_err   = ERR_WR_REJ;
                    end
                end else if (tmo_hit) begin
                    next_state = ST_FINISH;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_BUSY: begin
                if (busy_release) begin
                    next_state = ST_FINISH;
                end else if (tmo_hit) begin
                    next_state = ST_FINISH;
                    next_err   = ERR_TIMEOUT;
                end
            end
            ST_FINISH: begin
                odone      = 1'b1;
`ifdef D_CTRL_RETRY_EN
                next_retry = '0;
`endif
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule
